// File: rtl/fft_butterfly.sv
// Radix-2 DIF butterfly: SUM = A+B, DIFF = A-B on complex operands (re/im lanes independent).
// Latency: 1 cycle, all outputs registered; synchronous active-high reset clears every output.
// Backpressure: none; free-running pipeline, data registers load every cycle, in_valid only feeds out_valid.
//
// Ports (positional order is part of the interface):
//   a_re, a_im, b_re, b_im : operands A and B, signed WIDTH-bit
//   c                      : clock, rising edge
//   sum_re, sum_im         : registered A+B
//   diff_re, diff_im       : registered A-B
//   rst                    : synchronous reset, active-high, highest priority
//   in_valid / out_valid   : qualifier, delayed by one cycle
//   ovf                    : registered OR of the four per-lane overflow flags
//
// Parameters: WIDTH (lane width), SCALE (1 = halve results, floor rounding, never overflows).
// Build option: define FFT_BUTTERFLY_SAT_EN to clamp overflowing lanes (SCALE=0 only)
// instead of wrapping; ovf asserts either way.

module fft_butterfly #(
  parameter int WIDTH = 16,
  parameter int SCALE = 0
) (
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic             c,
  output logic [WIDTH-1:0] sum_re,
  output logic [WIDTH-1:0] sum_im,
  output logic [WIDTH-1:0] diff_re,
  output logic [WIDTH-1:0] diff_im,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             ovf
);

  typedef struct packed {
    logic             of;
    logic [WIDTH-1:0] val;
  } lane_t;

  // One real lane: exact WIDTH+1 result, then either halve it or fold it back to WIDTH.
  function automatic lane_t lane_op(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic             sub);
    lane_t          r;
    logic [WIDTH:0] ext;
    // Sign-extended operands make the WIDTH+1 result exact for both add and subtract.
    if (sub) ext = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    else     ext = {x[WIDTH-1], x} + {y[WIDTH-1], y};
    r.of  = 1'b0;
    r.val = ext[WIDTH-1:0];
    if (SCALE != 0) begin
      // Dropping the LSB of the exact value is an arithmetic shift (floor toward -inf),
      // and a halved WIDTH+1 value always fits WIDTH.
      r.val = ext[WIDTH:1];
    end else if (ext[WIDTH] != ext[WIDTH-1]) begin
      r.of = 1'b1;
`ifdef FFT_BUTTERFLY_SAT_EN
      // The extra top bit carries the true sign, which picks the clamp direction.
      r.val = ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end
    return r;
  endfunction

  lane_t sr_n, si_n, dr_n, di_n;

  always_comb begin
    sr_n = lane_op(a_re, b_re, 1'b0);
    si_n = lane_op(a_im, b_im, 1'b0);
    dr_n = lane_op(a_re, b_re, 1'b1);
    di_n = lane_op(a_im, b_im, 1'b1);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      sum_re    <= '0;
      sum_im    <= '0;
      diff_re   <= '0;
      diff_im   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sum_re    <= sr_n.val;
      sum_im    <= si_n.val;
      diff_re   <= dr_n.val;
      diff_im   <= di_n.val;
      out_valid <= in_valid;
      ovf       <= sr_n.of | si_n.of | dr_n.of | di_n.of;
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: one unscaled and one scaled instance share the same stimulus.
// Expected values come from integer arithmetic on the operand values.
// Honours FFT_BUTTERFLY_SAT_EN the same way the design does (clamp vs wrap on overflow).

module tb_fft_butterfly;
  localparam int W    = 16;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic         c = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a_re, a_im, b_re, b_im;

  logic [W-1:0] sum_re, sum_im, diff_re, diff_im;
  logic         out_valid, ovf;
  logic [W-1:0] s_sum_re, s_sum_im, s_diff_re, s_diff_im;
  logic         s_out_valid, s_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 c = ~c;

  fft_butterfly #(.WIDTH(W), .SCALE(0)) dut (
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .c(c),
    .sum_re(sum_re), .sum_im(sum_im), .diff_re(diff_re), .diff_im(diff_im),
    .rst(rst), .in_valid(in_valid), .out_valid(out_valid), .ovf(ovf)
  );

  fft_butterfly #(.WIDTH(W), .SCALE(1)) dut_s (
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .c(c),
    .sum_re(s_sum_re), .sum_im(s_sum_im), .diff_re(s_diff_re), .diff_im(s_diff_im),
    .rst(rst), .in_valid(in_valid), .out_valid(s_out_valid), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference lane: exact integer result, then halve (floor) or wrap/clamp to 16 bits.
  function automatic int model_lane(input int s, input bit scale, output bit o);
    int r;
    o = 1'b0;
    r = s;
    if (scale) begin
      if (s >= 0) r = s / 2;
      else        r = -((-s + 1) / 2);
    end else if (s > MAXV) begin
      o = 1'b1;
`ifdef FFT_BUTTERFLY_SAT_EN
      r = MAXV;
`else
      r = s - 65536;
`endif
    end else if (s < MINV) begin
      o = 1'b1;
`ifdef FFT_BUTTERFLY_SAT_EN
      r = MINV;
`else
      r = s + 65536;
`endif
    end
    return r;
  endfunction

  function automatic int sv(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  // Apply one operand set for one clock, then compare both instances against the model.
  task automatic step(input int ar, input int ai, input int br, input int bi,
                      input bit vld, input bit r);
    int e_sr, e_si, e_dr, e_di, x_sr, x_si, x_dr, x_di;
    bit o0, o1, o2, o3, d;
    rst      = r;
    in_valid = vld;
    a_re = W'(ar); a_im = W'(ai); b_re = W'(br); b_im = W'(bi);
    e_sr = model_lane(ar + br, 1'b0, o0);
    e_si = model_lane(ai + bi, 1'b0, o1);
    e_dr = model_lane(ar - br, 1'b0, o2);
    e_di = model_lane(ai - bi, 1'b0, o3);
    x_sr = model_lane(ar + br, 1'b1, d);
    x_si = model_lane(ai + bi, 1'b1, d);
    x_dr = model_lane(ar - br, 1'b1, d);
    x_di = model_lane(ai - bi, 1'b1, d);
    if (r) begin
      e_sr = 0; e_si = 0; e_dr = 0; e_di = 0;
      x_sr = 0; x_si = 0; x_dr = 0; x_di = 0;
      o0 = 0; o1 = 0; o2 = 0; o3 = 0; vld = 0;
    end
    @(posedge c);
    #1;
    chk("sum_re",    sv(sum_re),  e_sr);
    chk("sum_im",    sv(sum_im),  e_si);
    chk("diff_re",   sv(diff_re), e_dr);
    chk("diff_im",   sv(diff_im), e_di);
    chk("out_valid", int'(out_valid), int'(vld));
    chk("ovf",       int'(ovf), int'(o0 | o1 | o2 | o3));
    chk("s_sum_re",  sv(s_sum_re),  x_sr);
    chk("s_sum_im",  sv(s_sum_im),  x_si);
    chk("s_diff_re", sv(s_diff_re), x_dr);
    chk("s_diff_im", sv(s_diff_im), x_di);
    chk("s_out_valid", int'(s_out_valid), int'(vld));
    chk("s_ovf",     int'(s_ovf), 0);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 7))
      0:       return MINV;
      1:       return MAXV;
      2:       return int'($urandom_range(0, 3)) - 2;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;

    // Reset held two cycles with nonzero operands.
    step(1234, -200, 300, 4000, 1'b1, 1'b1);
    step(-5, 77, 32767, -32768, 1'b1, 1'b1);
    chk("rst_sum_re_zero", sv(sum_re), 0);

    // Basic complex butterfly.
    step(5, -3, 2, 7, 1'b1, 1'b0);
    chk("t2_sum_re", sv(sum_re), 7);
    chk("t2_sum_im", sv(sum_im), 4);
    chk("t2_diff_re", sv(diff_re), 3);
    chk("t2_diff_im", sv(diff_im), -10);

    // Positive overflow on sum.
    step(32767, 0, 1, 0, 1'b1, 1'b0);
`ifdef FFT_BUTTERFLY_SAT_EN
    chk("t3_sum_re", sv(sum_re), 32767);
`else
    chk("t3_sum_re", sv(sum_re), -32768);
`endif
    chk("t3_ovf", int'(ovf), 1);

    // Negative overflow on difference.
    step(-32768, 0, 1, 0, 1'b0, 1'b0);
`ifdef FFT_BUTTERFLY_SAT_EN
    chk("t4_diff_re", sv(diff_re), -32768);
`else
    chk("t4_diff_re", sv(diff_re), 32767);
`endif
    chk("t4_ovf", int'(ovf), 1);

    // Scaled instance: growth absorbed, floor rounding.
    step(32767, 3, 32767, 0, 1'b1, 1'b0);
    chk("t5_s_sum_re", sv(s_sum_re), 32767);
    chk("t5_s_diff_re", sv(s_diff_re), 0);
    chk("t5_s_sum_im_3", sv(s_sum_im), 1);
    step(0, -3, 0, 0, 1'b1, 1'b0);
    chk("t5_s_sum_im_m3", sv(s_sum_im), -2);

    // Boundaries: min - min, all zero.
    step(-32768, -32768, -32768, -32768, 1'b1, 1'b0);
    chk("min_minus_min", sv(diff_re), 0);
    step(0, 0, 0, 0, 1'b1, 1'b0);
    chk("zero_sum_im", sv(sum_im), 0);

    // Reset mid-stream on the third of four vectors.
    step(10, 20, 30, 40, 1'b1, 1'b0);
    step(-11, 22, -33, 44, 1'b1, 1'b0);
    step(100, 200, 300, 400, 1'b1, 1'b1);
    chk("t6_rst_vld", int'(out_valid), 0);
    step(9, -9, 4, 4, 1'b1, 1'b0);
    chk("t6_resume_sum_re", sv(sum_re), 13);
    chk("t6_resume_vld", int'(out_valid), 1);

    // Randomized operands, occasional valid gaps and resets.
    for (int i = 0; i < 300; i++) begin
      step(rnd_val(), rnd_val(), rnd_val(), rnd_val(),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
